// File: rtl/scfa_sweep_ctrl_if.sv
// Operand/result bundle between the sweep controller and the comparator path.
// The master side is the controller: it drives operands and publishes the sweep results.
interface scfa_sweep_ctrl_if;
    logic        start;
    logic [1:0]  drv_A;
    logic [1:0]  drv_B;
    logic [1:0]  ret_in;
    logic        busy;
    logic        done;
    logic [15:0] result_map;
    logic [4:0]  ones_count;
    logic        err;
    logic [3:0]  err_idx;

    modport master (
        input  start, ret_in,
        output drv_A, drv_B, busy, done, result_map, ones_count, err, err_idx
    );

    modport slave (
        output start, ret_in,
        input  drv_A, drv_B, busy, done, result_map, ones_count, err, err_idx
    );
endinterface

// File: rtl/scfa_sweep_ctrl.sv
// Sweeps all 16 (A,B) operand pairs through the compare path and collects a truth-table
// bitmap, a count of asserted results and a sticky malformed-code error.
module scfa_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    scfa_sweep_ctrl_if.master  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_SAMPLE,
        S_DONE
    } state_e;

    localparam logic [3:0] WAIT_LAST = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;

    state_e      state_q;
    logic [3:0]  idx_q;
    logic [3:0]  wait_q;
    logic [1:0]  drv_a_q;
    logic [1:0]  drv_b_q;
    logic        busy_q;
    logic        done_q;
    logic [15:0] map_q;
    logic [4:0]  ones_q;
    logic        err_q;
    logic [3:0]  err_idx_q;

    logic        malformed;
    assign malformed = bus.ret_in[1] ^ bus.ret_in[0];

    // NOTE: all state lives in one clocked block using <= only, so every register sees
    // the pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            wait_q    <= '0;
            drv_a_q   <= '0;
            drv_b_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            map_q     <= '0;
            ones_q    <= '0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        map_q     <= '0;
                        ones_q    <= '0;
                        err_q     <= 1'b0;
                        err_idx_q <= '0;
                        idx_q     <= '0;
                        drv_a_q   <= '0;
                        drv_b_q   <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    wait_q  <= '0;
                    state_q <= (SETTLE_CYCLES > 0) ? S_WAIT : S_SAMPLE;
                end
                S_WAIT: begin
                    if (wait_q == WAIT_LAST) begin
                        state_q <= S_SAMPLE;
                    end else begin
                        wait_q <= wait_q + 4'd1;
                    end
                end
                S_SAMPLE: begin
                    map_q[idx_q] <= bus.ret_in[0];
                    if (bus.ret_in == 2'b11) begin
                        ones_q <= ones_q + 5'd1;
                    end
                    // Only the first malformed code is recorded; err stays sticky.
                    if (malformed && !err_q) begin
                        err_q     <= 1'b1;
                        err_idx_q <= idx_q;
                    end
                    if (idx_q == 4'd15) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        idx_q              <= idx_q + 4'd1;
                        {drv_a_q, drv_b_q} <= idx_q + 4'd1;
                        state_q            <= S_DRIVE;
                    end
                end
                S_DONE: begin
                    drv_a_q <= '0;
                    drv_b_q <= '0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.drv_A      = drv_a_q;
    assign bus.drv_B      = drv_b_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.result_map = map_q;
    assign bus.ones_count = ones_q;
    assign bus.err        = err_q;
    assign bus.err_idx    = err_idx_q;
endmodule

// File: tb/tb_scfa_sweep_ctrl.sv
// Directed bench for scfa_sweep_ctrl: one instance with one settle cycle, one with none,
// each driven by a behavioural comparator that can be switched to fault or tie-high modes.
module tb_scfa_sweep_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    scfa_sweep_ctrl_if if_s0 ();
    scfa_sweep_ctrl_if if_s1 ();

    scfa_sweep_ctrl #(.SETTLE_CYCLES(0)) u_dut_s0 (.clk(clk), .rst(rst), .bus(if_s0.master));
    scfa_sweep_ctrl #(.SETTLE_CYCLES(1)) u_dut_s1 (.clk(clk), .rst(rst), .bus(if_s1.master));

    // Comparator modes: 0 = reference, 1 = malformed codes at idx 5 and 9, 2 = tied to 2'b11.
    logic [1:0] mode_v  [2];
    logic       start_v [2];

    function automatic logic [1:0] ref_ret(input logic [1:0] a, input logic [1:0] b,
                                           input logic [1:0] mode);
        logic [1:0] ap;
        ap = a + 2'd1;
        if (mode == 2'd2) return 2'b11;
        if (mode == 2'd1 && {a, b} == 4'd5) return 2'b10;
        if (mode == 2'd1 && {a, b} == 4'd9) return 2'b01;
        return (ap > b || ap == 2'd3) ? 2'b11 : 2'b00;
    endfunction

    assign if_s0.start  = start_v[0];
    assign if_s1.start  = start_v[1];
    assign if_s0.ret_in = ref_ret(if_s0.drv_A, if_s0.drv_B, mode_v[0]);
    assign if_s1.ret_in = ref_ret(if_s1.drv_A, if_s1.drv_B, mode_v[1]);

    logic        busy_w [2];
    logic        done_w [2];
    logic [3:0]  drv_w  [2];
    logic [15:0] map_w  [2];
    logic [4:0]  ones_w [2];
    logic        err_w  [2];
    logic [3:0]  eidx_w [2];

    assign busy_w[0] = if_s0.busy;        assign busy_w[1] = if_s1.busy;
    assign done_w[0] = if_s0.done;        assign done_w[1] = if_s1.done;
    assign drv_w[0]  = {if_s0.drv_A, if_s0.drv_B};
    assign drv_w[1]  = {if_s1.drv_A, if_s1.drv_B};
    assign map_w[0]  = if_s0.result_map;  assign map_w[1]  = if_s1.result_map;
    assign ones_w[0] = if_s0.ones_count;  assign ones_w[1] = if_s1.ones_count;
    assign err_w[0]  = if_s0.err;         assign err_w[1]  = if_s1.err;
    assign eidx_w[0] = if_s0.err_idx;     assign eidx_w[1] = if_s1.err_idx;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input int d);
        check("rst_busy", busy_w[d], 0);
        check("rst_done", done_w[d], 0);
        check("rst_drv",  drv_w[d],  0);
        check("rst_map",  map_w[d],  0);
        check("rst_ones", ones_w[d], 0);
        check("rst_err",  err_w[d],  0);
        check("rst_eidx", eidx_w[d], 0);
    endtask

    // Called on the negedge of the first DRIVE cycle; returns cycles until done is seen.
    task automatic wait_done(input int d, input int per, output int k);
        k = 0;
        while (!done_w[d] && k < 200) begin
            if (k < 16 * per) check("drv_step", drv_w[d], 32'(k / per));
            @(negedge clk);
            k++;
        end
        if (k >= 200) check("done_timeout", 0, 1);
    endtask

    task automatic check_results(input int d, input logic [15:0] emap, input logic [4:0] eones,
                                 input logic eerr, input logic [3:0] eidx);
        check("map",     map_w[d],  emap);
        check("ones",    ones_w[d], eones);
        check("err",     err_w[d],  eerr);
        check("err_idx", eidx_w[d], eidx);
    endtask

    task automatic run_sweep(input int d, input int per, input logic [15:0] emap,
                             input logic [4:0] eones, input logic eerr, input logic [3:0] eidx);
        int k;
        @(negedge clk); start_v[d] = 1'b1;
        @(negedge clk); start_v[d] = 1'b0;
        check("busy_rise", busy_w[d], 1);
        check("clr_map",   map_w[d],  0);
        check("clr_ones",  ones_w[d], 0);
        check("clr_err",   err_w[d],  0);
        wait_done(d, per, k);
        check("latency", k, 16 * per);
        check("busy_at_done", busy_w[d], 0);
        check_results(d, emap, eones, eerr, eidx);
        @(negedge clk);
        check("done_one_cycle", done_w[d], 0);
        check("drv_idle", drv_w[d], 0);
        check_results(d, emap, eones, eerr, eidx);
    endtask

    initial begin
        int k;
        int done_seen;
        checks     = 0;
        errors     = 0;
        mode_v[0]  = 2'd0;
        mode_v[1]  = 2'd0;
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
        rst        = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals(0);
        check_reset_vals(1);
        rst = 1'b0;

        // Reference sweeps with and without a settle cycle.
        run_sweep(1, 3, 16'h0F31, 5'd7, 1'b0, 4'd0);
        run_sweep(0, 2, 16'h0F31, 5'd7, 1'b0, 4'd0);

        // Malformed codes: first one wins, next start clears.
        mode_v[1] = 2'd1;
        run_sweep(1, 3, 16'h0F11, 5'd5, 1'b1, 4'd5);
        mode_v[1] = 2'd0;
        run_sweep(1, 3, 16'h0F31, 5'd7, 1'b0, 4'd0);

        // start held high: back-to-back sweeps, restart two cycles after done.
        @(negedge clk); start_v[1] = 1'b1;
        @(negedge clk);
        check("held_busy1", busy_w[1], 1);
        wait_done(1, 3, k);
        check("held_lat1", k, 48);
        check_results(1, 16'h0F31, 5'd7, 1'b0, 4'd0);
        @(negedge clk);
        check("held_gap_busy", busy_w[1], 0);
        check("held_gap_done", done_w[1], 0);
        @(negedge clk);
        check("held_busy2", busy_w[1], 1);
        wait_done(1, 3, k);
        check("held_lat2", k, 48);
        start_v[1] = 1'b0;
        check_results(1, 16'h0F31, 5'd7, 1'b0, 4'd0);
        @(negedge clk);
        check("held_end_done", done_w[1], 0);
        @(negedge clk);
        check("held_no_restart", busy_w[1], 0);

        // Reset during WAIT of idx 7 aborts the sweep with no done pulse.
        @(negedge clk); start_v[1] = 1'b1;
        @(negedge clk); start_v[1] = 1'b0;
        repeat (22) @(negedge clk);
        check("pre_rst_drv",  drv_w[1],  7);
        check("pre_rst_ones", ones_w[1], 3);
        rst = 1'b1;
        #1;
        check_reset_vals(1);
        @(negedge clk); rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done_w[1] || busy_w[1]) done_seen++;
        end
        check("no_done_after_rst", done_seen, 0);
        run_sweep(1, 3, 16'h0F31, 5'd7, 1'b0, 4'd0);

        // All results asserted: counter reaches 16 without wrapping.
        mode_v[0] = 2'd2;
        run_sweep(0, 2, 16'hFFFF, 5'd16, 1'b0, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
